uart_receiver: RTL and testbench

//  UART serial receiver, far end of the link driven by the project Transmitter.

---
 rtl/uart_receiver.sv | 125 ++++++++++++
 tb/tb_uart_receiver.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/uart_receiver.sv
// rtl/uart_receiver.sv - UART receiver, 16x oversampled on s_tick, DBit data bits LSB first.
module uart_receiver #(
  parameter int DBit = 8,
  parameter int SBit = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       s_tick,
  input  logic       rx,
  output logic [7:0] rx_dout,
  output logic       rx_done_tick,
  output logic       rx_frame_err
);

  localparam int SW = (SBit > 16) ? $clog2(SBit) : 4;
  localparam logic [SW-1:0] S_MID  = SW'(7);
  localparam logic [SW-1:0] S_BIT  = SW'(15);
  localparam logic [SW-1:0] S_STOP = SW'(SBit - 1);
  localparam logic [2:0]    N_LAST = 3'(DBit - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state, state_next;
  logic [SW-1:0] s, s_next;
  logic [2:0]    n, n_next;
  logic [7:0]    b, b_next;
  logic [7:0]    dout_next;
  logic          err_next, done_next;
  logic          rx_m, rx_s;

  // Synchronizer idles high so reset never looks like a start edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      s            <= '0;
      n            <= '0;
      b            <= '0;
      rx_dout      <= '0;
      rx_frame_err <= 1'b0;
      rx_done_tick <= 1'b0;
    end else begin
      state        <= state_next;
      s            <= s_next;
      n            <= n_next;
      b            <= b_next;
      rx_dout      <= dout_next;
      rx_frame_err <= err_next;
      rx_done_tick <= done_next;
    end
  end

  always_comb begin
    state_next = state;
    s_next     = s;
    n_next     = n;
    b_next     = b;
    dout_next  = rx_dout;
    err_next   = rx_frame_err;
    done_next  = 1'b0;
    case (state)
      IDLE: begin
        if (!rx_s) begin
          state_next = START;
          s_next     = '0;
        end
      end
      START: begin
        if (s_tick) begin
          if (s == S_MID) begin
            // Line back high at mid start bit means a glitch, not a frame.
            if (!rx_s) begin
              state_next = DATA;
              s_next     = '0;
              n_next     = '0;
            end else begin
              state_next = IDLE;
            end
          end else begin
            s_next = s + SW'(1);
          end
        end
      end
      DATA: begin
        if (s_tick) begin
          if (s == S_BIT) begin
            s_next            = '0;
            b_next            = b >> 1;
            b_next[DBit-1]    = rx_s;
            if (n == N_LAST) begin
              state_next = STOP;
            end else begin
              n_next = n + 3'd1;
            end
          end else begin
            s_next = s + SW'(1);
          end
        end
      end
      STOP: begin
        if (s_tick) begin
          if (s == S_STOP) begin
            dout_next  = b;
            err_next   = ~rx_s;
            done_next  = 1'b1;
            state_next = IDLE;
          end else begin
            s_next = s + SW'(1);
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_receiver.sv
// tb/tb_uart_receiver.sv - Table-driven bench for uart_receiver (8N1, DBit=7 and SBit=32 variants).
module tb_uart_receiver;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       s_tick = 1'b0;
  logic [1:0] div = 2'd0;
  int         tick_cnt = 0;
  logic       rx_line = 1'b1;
  int         sel = 0;
  int         frame_start = 0;

  logic       rx_a, rx_b, rx_c;
  logic [7:0] dout_a, dout_b, dout_c;
  logic       done_a, done_b, done_c;
  logic       err_a, err_b, err_c;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [7:0] d;
    logic       e;
    int         t;
  } rec_t;
  rec_t qa[$], qb[$], qc[$];

  typedef struct {
    logic [7:0] data;
    logic       stop_good;
    int         idle_ticks;
    logic [7:0] exp_dout;
    logic       exp_err;
  } vec_t;
  vec_t vecs[7];

  assign rx_a = (sel == 0) ? rx_line : 1'b1;
  assign rx_b = (sel == 1) ? rx_line : 1'b1;
  assign rx_c = (sel == 2) ? rx_line : 1'b1;

  uart_receiver dut_a (
    .clk(clk), .reset(reset), .s_tick(s_tick), .rx(rx_a),
    .rx_dout(dout_a), .rx_done_tick(done_a), .rx_frame_err(err_a)
  );
  uart_receiver #(.DBit(7)) dut_b (
    .clk(clk), .reset(reset), .s_tick(s_tick), .rx(rx_b),
    .rx_dout(dout_b), .rx_done_tick(done_b), .rx_frame_err(err_b)
  );
  uart_receiver #(.SBit(32)) dut_c (
    .clk(clk), .reset(reset), .s_tick(s_tick), .rx(rx_c),
    .rx_dout(dout_c), .rx_done_tick(done_c), .rx_frame_err(err_c)
  );

  always #5 clk = ~clk;

  // One s_tick every 4 clocks; tick_cnt counts ticks as the DUT sees them.
  always @(posedge clk) begin
    div    <= div + 2'd1;
    s_tick <= (div == 2'd3);
    if (s_tick) tick_cnt <= tick_cnt + 1;
  end

  always @(negedge clk) begin
    if (done_a) qa.push_back('{dout_a, err_a, tick_cnt});
    if (done_b) qb.push_back('{dout_b, err_b, tick_cnt});
    if (done_c) qc.push_back('{dout_c, err_c, tick_cnt});
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic wait_ticks(input int n);
    int target;
    target = tick_cnt + n;
    while (tick_cnt < target) @(negedge clk);
  endtask

  task automatic send_frame(input int which, input logic [7:0] data, input int nbits,
                            input logic stop_good, input int stop_ticks);
    sel         = which;
    frame_start = tick_cnt;
    rx_line     = 1'b0;
    wait_ticks(16);
    for (int i = 0; i < nbits; i++) begin
      rx_line = data[i];
      wait_ticks(16);
    end
    if (stop_good) begin
      rx_line = 1'b1;
      wait_ticks(stop_ticks);
    end else begin
      rx_line = 1'b0;
      wait_ticks(10);
      rx_line = 1'b1;
      wait_ticks(stop_ticks - 10);
    end
  endtask

  task automatic pop(inout rec_t q[$], output rec_t r);
    if (q.size() > 0) r = q.pop_front();
    else r = '{8'hxx, 1'bx, -1};
  endtask

  initial begin
    rec_t r;
    int   n0;

    vecs[0] = '{8'hA5, 1'b1, 20, 8'hA5, 1'b0};
    vecs[1] = '{8'h55, 1'b0, 20, 8'h55, 1'b1};
    vecs[2] = '{8'h0F, 1'b1, 20, 8'h0F, 1'b0};
    vecs[3] = '{8'h00, 1'b1,  0, 8'h00, 1'b0};
    vecs[4] = '{8'hFF, 1'b1,  0, 8'hFF, 1'b0};
    vecs[5] = '{8'h81, 1'b1, 20, 8'h81, 1'b0};
    vecs[6] = '{8'h55, 1'b0, 20, 8'h55, 1'b1};

    repeat (3) @(negedge clk);
    check("reset_dout", 32'(dout_a), 32'h0);
    check("reset_done", 32'(done_a), 32'h0);
    check("reset_err",  32'(err_a),  32'h0);
    reset = 1'b0;
    wait_ticks(20);

    // Short low glitch must be rejected at mid start bit.
    rx_line = 1'b0;
    wait_ticks(5);
    rx_line = 1'b1;
    wait_ticks(30);
    check("false_start_no_done", 32'(qa.size()), 32'd0);

    foreach (vecs[i]) begin
      n0 = qa.size();
      send_frame(0, vecs[i].data, 8, vecs[i].stop_good, 16);
      check($sformatf("v%0d_done_count", i), 32'(qa.size() - n0), 32'd1);
      pop(qa, r);
      check($sformatf("v%0d_dout", i), 32'(r.d), 32'(vecs[i].exp_dout));
      check($sformatf("v%0d_err", i),  32'(r.e), 32'(vecs[i].exp_err));
      check($sformatf("v%0d_latency", i), 32'(r.t - frame_start), 32'd152);
      qa.delete();
      wait_ticks(vecs[i].idle_ticks);
    end

    // Reset in the middle of data bit 3 of 0x3C.
    sel     = 0;
    rx_line = 1'b0;
    wait_ticks(16);
    rx_line = 1'b0; wait_ticks(16);
    rx_line = 1'b0; wait_ticks(16);
    rx_line = 1'b1; wait_ticks(16);
    rx_line = 1'b1; wait_ticks(8);
    reset   = 1'b1;
    rx_line = 1'b1;
    repeat (2) @(negedge clk);
    check("midreset_dout", 32'(dout_a), 32'h0);
    check("midreset_done", 32'(done_a), 32'h0);
    check("midreset_err",  32'(err_a),  32'h0);
    reset = 1'b0;
    wait_ticks(40);
    check("midreset_no_done", 32'(qa.size()), 32'd0);
    send_frame(0, 8'h3C, 8, 1'b1, 16);
    check("after_reset_count", 32'(qa.size()), 32'd1);
    pop(qa, r);
    check("after_reset_dout", 32'(r.d), 32'h3C);
    check("after_reset_err",  32'(r.e), 32'h0);
    wait_ticks(20);

    // DBit=7 variant.
    send_frame(1, 8'h7F, 7, 1'b1, 16);
    wait_ticks(20);
    send_frame(1, 8'h2A, 7, 1'b1, 16);
    wait_ticks(20);
    check("dbit7_count", 32'(qb.size()), 32'd2);
    pop(qb, r);
    check("dbit7_dout_7f", 32'(r.d), 32'h7F);
    check("dbit7_err",     32'(r.e), 32'h0);
    pop(qb, r);
    check("dbit7_dout_2a", 32'(r.d), 32'h2A);

    // SBit=32 variant: done lands 32 ticks after the last data sample.
    send_frame(2, 8'h12, 8, 1'b1, 32);
    wait_ticks(20);
    check("sbit32_count", 32'(qc.size()), 32'd1);
    pop(qc, r);
    check("sbit32_dout", 32'(r.d), 32'h12);
    check("sbit32_err",  32'(r.e), 32'h0);
    check("sbit32_stop_ticks", 32'(r.t - (frame_start + 8 + 16 * 8)), 32'd32);

    check("idle_a_no_extra", 32'(qa.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
